inst_buffer: RTL and testbench
==============================

INST_BUFFER -- requirements
Module: inst_buffer

Interface
REQ-001 Parameter: DEPTH, default 4, number of entries; power of two, minimum 2.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: flush  input  1  synchronous discard of all entries (branch redirect / exception).
REQ-005 Port: in_valid  input  1  fetch presents an instruction.
REQ-006 Port: in_ready  output  1  buffer accepts the instruction this cycle.
REQ-007 Port: in_pc  input  32  PC of the presented instruction.
REQ-008 Port: in_inst  input  32  instruction word.
REQ-009 Port: out_valid  output  1  decode-side instruction available.
REQ-010 Port: out_ready  input  1  decode stage consumes this cycle.
REQ-011 Port: out_pc  output  32  PC of head entry.
REQ-012 Port: out_inst  output  32  instruction word of head entry; feeds the opcode/register decoders.
REQ-013 Port: count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-014 Storage SHALL be a circular buffer with read and write pointers, each $clog2(DEPTH)+1 bits (wrap bit in MSB).
REQ-015 Empty SHALL be pointers equal; full SHALL be low bits equal and MSBs different.
REQ-016 Push SHALL occur on in_valid && in_ready; pop SHALL occur on out_valid && out_ready.
REQ-017 in_ready SHALL equal !full && !flush; it SHALL NOT depend on out_ready.
REQ-018 out_valid SHALL equal !empty && !flush (bypass case per REQ-027).
REQ-019 When out_valid is 0, out_pc and out_inst SHALL be 0; otherwise they SHALL be the head entry.
REQ-020 Write-to-read latency SHALL be 1 cycle: an entry pushed at edge N is at the output after edge N.
REQ-021 Simultaneous push and pop SHALL leave count unchanged and advance both pointers, including when full is 0 and count is 1.
REQ-022 Pointer increment SHALL wrap modulo 2*DEPTH; the entry index is the low $clog2(DEPTH) bits.
REQ-023 count SHALL equal the write pointer minus the read pointer, modulo 2*DEPTH.
REQ-024 Flush SHALL take priority over push and pop: at the next edge both pointers become 0; data presented during the flush cycle is dropped.
REQ-025 Data order SHALL be strictly FIFO; no entry is duplicated or skipped across wrap-around.

Reset
REQ-026 At an edge with reset high, both pointers and count SHALL become 0, so out_valid is 0, in_ready is 1, and out_pc and out_inst are 0. Storage array contents are not reset. Reset overrides flush, push and pop, including when it is asserted mid-stream.

Configuration
REQ-027 With INST_BUFFER_BYPASS_EN defined: when the buffer is empty, in_valid is 1 and flush is 0, out_valid SHALL be 1 with out_pc and out_inst driven combinationally from in_pc and in_inst. If out_ready is also 1, the entry SHALL NOT be written and the pointers SHALL hold. If out_ready is 0, the entry SHALL be pushed normally.
REQ-028 Without INST_BUFFER_BYPASS_EN: there is no combinational in-to-out path, and the minimum latency is 1 cycle per REQ-020.

Structure
REQ-029 A shared package/header SHALL hold PC_W=32, INST_W=32 and the NOP encoding constant; the block SHALL use these, not literals.
REQ-030 One sub-module, ibuf_ptr (a wrap-bit pointer register with synchronous clear and increment), SHALL be instantiated twice, once for read and once for write.
REQ-031 The storage array SHALL be a plain register array with no reset, inferable as distributed RAM.

Verification
REQ-032 Reset, then push pc=0x1c000000 inst=0x02800c0c with out_ready=0 -> after 1 edge: out_valid=1, out_pc=0x1c000000, count=1.
REQ-033 DEPTH=4, push 4 entries with out_ready=0 -> count=4, in_ready=0; a 5th in_valid is not accepted; then pop 4 -> data in order and empty.
REQ-034 Continuous push and pop at count=2 for 10 cycles across pointer wrap -> count stays 2 and the pc sequence is contiguous (+4 each).
REQ-035 count=3 with flush=1 and in_valid=1 -> in_ready=0 and out_valid=0 in that cycle; next cycle count=0 and the flushed-cycle data never appears.
REQ-036 Reset asserted at count=2 while a push and pop are active -> next cycle count=0 and out_valid=0; storage contents are not observable.
REQ-037 With INST_BUFFER_BYPASS_EN, empty buffer with in_valid=1 and out_ready=1 -> out_pc equals in_pc in the same cycle and count stays 0; without the macro -> out_valid=0 that cycle.

Source files
------------

// File: rtl/inst_buffer_pkg.sv
// Shared widths and constants for the instruction buffer between fetch and decode.
package inst_buffer_pkg;
   localparam int PC_W   = 32;
   localparam int INST_W = 32;
   // andi r0, r0, 0: canonical no-op encoding
   localparam logic [INST_W-1:0] NOP_INST = 32'h0340_0000;

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [INST_W-1:0] inst;
   } ibuf_entry_t;
endpackage

// File: rtl/inst_buffer_ptr.sv
// Wrap-bit pointer register: synchronous reset/clear to zero, increments modulo 2**PTR_W.
module ibuf_ptr #(
   parameter int PTR_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             inc,
   output logic [PTR_W-1:0] ptr
);
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= ptr + 1'b1;
      end
   end
endmodule

// File: rtl/inst_buffer.sv
// Fetch-to-decode instruction FIFO with flush. Define INST_BUFFER_BYPASS_EN to let an
// instruction arriving at an empty buffer reach decode in the same cycle.
module inst_buffer
   import inst_buffer_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [PC_W-1:0]            in_pc,
   input  logic [INST_W-1:0]          in_inst,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [PC_W-1:0]            out_pc,
   output logic [INST_W-1:0]          out_inst,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0] wr_ptr, rd_ptr;
   logic          empty, full, bypass;
   logic          push_fire, pop_fire, wr_inc, rd_inc;
   ibuf_entry_t   mem [DEPTH];
   ibuf_entry_t   head;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

`ifdef INST_BUFFER_BYPASS_EN
   assign bypass = empty && in_valid && !flush;
`else
   assign bypass = 1'b0;
`endif

   assign in_ready  = !full && !flush;
   assign out_valid = (!empty && !flush) || bypass;
   assign push_fire = in_valid && in_ready;
   assign pop_fire  = out_valid && out_ready;
   // A bypassed instruction consumed by decode never touches storage.
   assign wr_inc    = push_fire && !(bypass && out_ready);
   assign rd_inc    = pop_fire && !empty;

   ibuf_ptr #(.PTR_W(PW)) u_wr_ptr (
      .clk   (clk),
      .reset (reset),
      .clear (flush),
      .inc   (wr_inc),
      .ptr   (wr_ptr)
   );

   ibuf_ptr #(.PTR_W(PW)) u_rd_ptr (
      .clk   (clk),
      .reset (reset),
      .clear (flush),
      .inc   (rd_inc),
      .ptr   (rd_ptr)
   );

   always_ff @(posedge clk) begin
      if (wr_inc) begin
         mem[wr_ptr[AW-1:0]] <= '{pc: in_pc, inst: in_inst};
      end
   end

   always_comb begin
      head = mem[rd_ptr[AW-1:0]];
      if (bypass) begin
         out_pc   = in_pc;
         out_inst = in_inst;
      end else if (out_valid) begin
         out_pc   = head.pc;
         out_inst = head.inst;
      end else begin
         out_pc   = '0;
         out_inst = '0;
      end
   end

   assign count = wr_ptr - rd_ptr;
endmodule

// File: tb/tb_inst_buffer.sv
// Directed bench for inst_buffer: driver queues expected entries, a negedge monitor checks every handshake.
module tb_inst_buffer;
   logic        clk = 1'b0;
   logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_pc, in_inst, out_pc, out_inst;
   logic [2:0]  count;

   int checks = 0;
   int failures = 0;
   logic [63:0] exp_q[$];

   inst_buffer #(.DEPTH(4)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
      .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst, input logic expect_accept);
      in_valid = v;
      in_pc    = pc;
      in_inst  = inst;
      if (v && expect_accept) exp_q.push_back({pc, inst});
   endtask

   // Monitor: every decode handshake must match the head of the expected queue.
   always @(negedge clk) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL pop_unexpected actual_pc=0x%08h required=none", out_pc);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            if ({out_pc, out_inst} !== e) begin
               failures++;
               $display("FAIL pop_data actual=%016h required=%016h", {out_pc, out_inst}, e);
            end
         end
      end else if (out_valid === 1'b0) begin
         checks++;
         if (out_pc !== 32'h0 || out_inst !== 32'h0) begin
            failures++;
            $display("FAIL idle_zero actual=%016h required=0", {out_pc, out_inst});
         end
      end
   end

   initial begin
      reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      step(); step();
      reset = 1'b0;
      #1;
      chk("rst_count", 32'(count), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_out_pc", out_pc, 0);

      // First push, one-cycle latency
      drive(1'b1, 32'h1c00_0000, 32'h0280_0c0c, 1'b1);
      step();
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      #1;
      chk("first_out_valid", 32'(out_valid), 1);
      chk("first_out_pc", out_pc, 32'h1c00_0000);
      chk("first_count", 32'(count), 1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("first_drain_count", 32'(count), 0);

      // Fill to full, reject a fifth, drain in order
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 1'b1);
         step();
      end
      drive(1'b1, 32'h999, 32'h999, 1'b0);
      #1;
      chk("full_count", 32'(count), 4);
      chk("full_in_ready", 32'(in_ready), 0);
      step();
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      chk("full_reject_count", 32'(count), 4);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) step();
      out_ready = 1'b0;
      #1;
      chk("drain_count", 32'(count), 0);
      chk("drain_out_valid", 32'(out_valid), 0);

      // Steady push+pop at count 2 across pointer wrap
      drive(1'b1, 32'h200, 32'h1200, 1'b1); step();
      drive(1'b1, 32'h204, 32'h1204, 1'b1); step();
      out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         drive(1'b1, 32'h208 + 32'(4 * k), 32'h1208 + 32'(4 * k), 1'b1);
         step();
         chk("stream_count", 32'(count), 2);
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      step(); step();
      out_ready = 1'b0;
      chk("stream_drain_count", 32'(count), 0);

      // Flush at count 3 drops stored and presented data
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h300 + 32'(4 * i), 32'h1300 + 32'(i), 1'b1);
         step();
      end
      flush = 1'b1;
      drive(1'b1, 32'h3AA, 32'h13AA, 1'b0);
      #1;
      chk("flush_count_before", 32'(count), 3);
      chk("flush_in_ready", 32'(in_ready), 0);
      chk("flush_out_valid", 32'(out_valid), 0);
      step();
      exp_q.delete();
      flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      #1;
      chk("flush_count_after", 32'(count), 0);
      chk("flush_out_valid_after", 32'(out_valid), 0);
      out_ready = 1'b1;
      step(); step();
      out_ready = 1'b0;
      chk("flush_idle_count", 32'(count), 0);

      // Reset mid-stream with push and pop active
      drive(1'b1, 32'h400, 32'h1400, 1'b1); step();
      drive(1'b1, 32'h404, 32'h1404, 1'b1); step();
      reset = 1'b1;
      out_ready = 1'b1;
      drive(1'b1, 32'h408, 32'h1408, 1'b0);
      step();
      exp_q.delete();
      reset = 1'b0;
      out_ready = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      #1;
      chk("midrst_count", 32'(count), 0);
      chk("midrst_out_valid", 32'(out_valid), 0);
      chk("midrst_out_pc", out_pc, 0);

      // Empty buffer, push with decode ready
      out_ready = 1'b1;
      drive(1'b1, 32'h500, 32'h1500, 1'b1);
      #1;
`ifdef INST_BUFFER_BYPASS_EN
      chk("byp_out_valid", 32'(out_valid), 1);
      chk("byp_out_pc", out_pc, 32'h500);
      step();
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      chk("byp_count", 32'(count), 0);
`else
      chk("nobyp_out_valid", 32'(out_valid), 0);
      step();
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      #1;
      chk("nobyp_count", 32'(count), 1);
      chk("nobyp_out_pc", out_pc, 32'h500);
      step();
      chk("nobyp_drain_count", 32'(count), 0);
`endif
      out_ready = 1'b0;
      step();
      chk("queue_empty", 32'(exp_q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
